// File: rtl/core_pkg.sv
// Shared types for the hazard controller: forward-select encodings, FSM states,
// and the destination-scoreboard entry.
package core_pkg;

    localparam int SB_DEPTH = 3;
    localparam int SB_EX    = 0;
    localparam int SB_MEM   = 1;
    localparam int SB_WB    = 2;
    localparam int SB_HIT_N = 2;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    // The youngest producer wins. The EX producer sits in MEM next cycle.
    function automatic fwd_sel_e fwd_pick(input logic hit_ex, input logic hit_mem);
        if (hit_ex) begin
            return FWD_MEM;
        end
        if (hit_mem) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundles the ID-stage instruction info with the hazard/forward controls
// exchanged between the datapath (master) and hazard_ctrl (slave).
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_write_back;
    logic             id_is_load;
    logic             id_is_ecall;
    logic             ex_brn_tkn;
    logic             stall_f;
    logic             bubble_e;
    logic             flush_d;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_write_back, id_is_load, id_is_ecall, ex_brn_tkn,
        input  stall_f, bubble_e, flush_d, fwd_a_sel, fwd_b_sel, halted,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_write_back, id_is_load, id_is_ecall, ex_brn_tkn,
        output stall_f, bubble_e, flush_d, fwd_a_sel, fwd_b_sel, halted,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sb.sv
// Three-entry destination scoreboard (EX, MEM, WB) that shifts every cycle,
// plus source-register match against the EX and MEM entries.
module hazard_sb
    import core_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  sb_entry_t           i_push,
    input  logic [4:0]          i_rs1,
    input  logic [4:0]          i_rs2,
    input  logic                i_use_rs1,
    input  logic                i_use_rs2,
    output logic [SB_HIT_N-1:0] o_hit_a,
    output logic [SB_HIT_N-1:0] o_hit_b,
    output logic                o_ld_hit,
    output logic                o_empty
);

    sb_entry_t             r_sb [SB_DEPTH];
    logic [SB_DEPTH-1:0]   w_valid;
    logic [SB_HIT_N-1:0]   w_hit_a;
    logic [SB_HIT_N-1:0]   w_hit_b;

    // Never frozen: hazards are resolved by pushing bubbles instead.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            r_sb[0] <= i_push;
            for (int i = 1; i < SB_DEPTH; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SB_DEPTH; gi++) begin : g_ent
            assign w_valid[gi] = r_sb[gi].valid;
            if (gi < SB_HIT_N) begin : g_hit
                assign w_hit_a[gi] = i_use_rs1 & r_sb[gi].valid & (r_sb[gi].rd == i_rs1);
                assign w_hit_b[gi] = i_use_rs2 & r_sb[gi].valid & (r_sb[gi].rd == i_rs2);
            end
        end
    endgenerate

    assign o_hit_a  = w_hit_a;
    assign o_hit_b  = w_hit_b;
    assign o_ld_hit = r_sb[SB_EX].is_load & (w_hit_a[SB_EX] | w_hit_b[SB_EX]);
    assign o_empty  = ~|w_valid;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: load-use and RAW stalls, branch flush, operand
// forwarding (when HAZARD_FWD_EN is defined), ecall drain-and-halt, perf counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic          clock,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    hz_state_e             r_state;
    hz_state_e             w_state_next;
    logic [SB_HIT_N-1:0]   w_hit_a;
    logic [SB_HIT_N-1:0]   w_hit_b;
    logic                  w_ld_hit;
    logic                  w_sb_empty;
    logic                  w_raw;
    logic                  w_stall_f;
    logic                  w_bubble_e;
    logic                  w_flush_d;
    logic                  w_halted;
    logic [1:0]            w_cnt_inc;
    sb_entry_t             w_push;

    assign w_push = '{valid:   hz.id_valid & hz.id_write_back & (hz.id_rd != 5'd0) & ~w_bubble_e,
                      rd:      hz.id_rd,
                      is_load: hz.id_is_load};

    hazard_sb u_sb (
        .clock     (clock),
        .reset     (reset),
        .i_push    (w_push),
        .i_rs1     (hz.id_rs1),
        .i_rs2     (hz.id_rs2),
        .i_use_rs1 (hz.id_use_rs1),
        .i_use_rs2 (hz.id_use_rs2),
        .o_hit_a   (w_hit_a),
        .o_hit_b   (w_hit_b),
        .o_ld_hit  (w_ld_hit),
        .o_empty   (w_sb_empty)
    );

`ifdef HAZARD_FWD_EN
    assign w_raw = hz.id_valid & w_ld_hit;
`else
    assign w_raw = hz.id_valid & (w_ld_hit | (|w_hit_a) | (|w_hit_b));
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A taken branch makes the ID instruction wrong-path, so it beats stall and ecall.
    always_comb begin
        w_state_next = r_state;
        w_stall_f    = 1'b0;
        w_bubble_e   = 1'b0;
        w_flush_d    = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            RUN: begin
                if (hz.ex_brn_tkn) begin
                    w_flush_d  = 1'b1;
                    w_bubble_e = 1'b1;
                end else begin
                    if (w_raw) begin
                        w_stall_f  = 1'b1;
                        w_bubble_e = 1'b1;
                    end
                    if (hz.id_valid && hz.id_is_ecall) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                w_stall_f  = 1'b1;
                w_bubble_e = 1'b1;
                if (w_sb_empty) begin
                    w_state_next = HALT;
                end
            end
            HALT: begin
                w_stall_f  = 1'b1;
                w_bubble_e = 1'b1;
                w_halted   = 1'b1;
            end
            default: w_state_next = RUN;
        endcase
    end

    assign hz.stall_f  = w_stall_f;
    assign hz.bubble_e = w_bubble_e;
    assign hz.flush_d  = w_flush_d;
    assign hz.halted   = w_halted;

`ifdef HAZARD_FWD_EN
    fwd_sel_e r_fwd_a;
    fwd_sel_e r_fwd_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (w_bubble_e) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_fwd_a <= fwd_pick(hz.id_valid & w_hit_a[SB_EX], hz.id_valid & w_hit_a[SB_MEM]);
            r_fwd_b <= fwd_pick(hz.id_valid & w_hit_b[SB_EX], hz.id_valid & w_hit_b[SB_MEM]);
        end
    end

    assign hz.fwd_a_sel = r_fwd_a;
    assign hz.fwd_b_sel = r_fwd_b;
`else
    assign hz.fwd_a_sel = FWD_RF;
    assign hz.fwd_b_sel = FWD_RF;
`endif

    // Index 0 counts stall cycles, index 1 counts flush events; both saturate.
    assign w_cnt_inc = {hz.ex_brn_tkn, w_stall_f & ~w_flush_d};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign hz.stall_cnt = g_cnt[0].r_cnt;
    assign hz.flush_cnt = g_cnt[1].r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expectations follow HAZARD_FWD_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clock;
    logic reset;
    int   n_vec     = 0;
    int   n_err     = 0;
    int   exp_stall = 0;

    hazard_ctrl_if #(.CNT_W(32)) hz ();

    hazard_ctrl #(.CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic wb, input logic ld, input logic ec);
        hz.id_valid      = v;
        hz.id_rs1        = rs1;
        hz.id_use_rs1    = u1;
        hz.id_rs2        = rs2;
        hz.id_use_rs2    = u2;
        hz.id_rd         = rd;
        hz.id_write_back = wb;
        hz.id_is_load    = ld;
        hz.id_is_ecall   = ec;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    // Present an instruction in ID, wait out its stall (bounded), then let it move to EX.
    task automatic issue(input string tag, input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic wb, input logic ld, input logic ec, input int exp_st);
        int n;
        n = 0;
        drive(v, rs1, u1, rs2, u2, rd, wb, ld, ec);
        #1;
        while (hz.stall_f === 1'b1 && n < 8) begin
            chk({tag, "/bubble"}, 32'(hz.bubble_e), 32'd1);
            step();
            n++;
        end
        $display("issue %-8s stall cycles=%0d", tag, n);
        chk({tag, "/stalls"}, 32'(n), 32'(exp_st));
        exp_stall += exp_st;
        step();
    endtask

    initial begin
        int n;
        reset         = 1'b0;
        hz.ex_brn_tkn = 1'b0;
        idle();
        #12;
        chk("rst/stall_f",   32'(hz.stall_f),   32'd0);
        chk("rst/bubble_e",  32'(hz.bubble_e),  32'd0);
        chk("rst/flush_d",   32'(hz.flush_d),   32'd0);
        chk("rst/halted",    32'(hz.halted),    32'd0);
        chk("rst/fwd_a",     32'(hz.fwd_a_sel), 32'd0);
        chk("rst/fwd_b",     32'(hz.fwd_b_sel), 32'd0);
        chk("rst/stall_cnt", hz.stall_cnt,      32'd0);
        chk("rst/flush_cnt", hz.flush_cnt,      32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();

        // lw x5,0(x1); add x6,x5,x2
        issue("lw_x5",  1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);
        issue("add_x6", 1, 5'd5, 1, 5'd2, 1, 5'd6, 1, 0, 0, FWD ? 1 : 2);
        chk("lu/fwd_a", 32'(hz.fwd_a_sel), FWD ? 32'd2 : 32'd0);
        chk("lu/fwd_b", 32'(hz.fwd_b_sel), 32'd0);
        chk("lu/stall_cnt", hz.stall_cnt, 32'(exp_stall));
        drain();

        // add x5,x1,x2; sub x7,x5,x5
        issue("add_x5", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0);
        issue("sub_x7", 1, 5'd5, 1, 5'd5, 1, 5'd7, 1, 0, 0, FWD ? 0 : 2);
        chk("exex/fwd_a", 32'(hz.fwd_a_sel), FWD ? 32'd1 : 32'd0);
        chk("exex/fwd_b", 32'(hz.fwd_b_sel), FWD ? 32'd1 : 32'd0);
        drain();

        // add x5; nop; or x8,x0,x5
        issue("add_x5b", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0);
        issue("nop",     0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        issue("or_x8",   1, 5'd0, 1, 5'd5, 1, 5'd8, 1, 0, 0, FWD ? 0 : 1);
        chk("memwb/fwd_a", 32'(hz.fwd_a_sel), 32'd0);
        chk("memwb/fwd_b", 32'(hz.fwd_b_sel), FWD ? 32'd2 : 32'd0);
        drain();

        // lw x0,0(x1); add x9,x0,x0 -- x0 never stalls or forwards
        issue("lw_x0",  1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0);
        issue("add_x9", 1, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0, 0);
        chk("x0/fwd_a", 32'(hz.fwd_a_sel), 32'd0);
        chk("x0/fwd_b", 32'(hz.fwd_b_sel), 32'd0);
        chk("x0/stall_cnt", hz.stall_cnt, 32'(exp_stall));
        drain();

        // Taken branch in EX coincident with load-use in ID
        issue("lw_x5c", 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);
        drive(1, 5'd5, 1, 5'd2, 1, 5'd6, 1, 0, 0);
        hz.ex_brn_tkn = 1'b1;
        #1;
        $display("branch with load-use in ID");
        chk("br/flush_d",  32'(hz.flush_d),  32'd1);
        chk("br/bubble_e", 32'(hz.bubble_e), 32'd1);
        chk("br/stall_f",  32'(hz.stall_f),  32'd0);
        step();
        hz.ex_brn_tkn = 1'b0;
        idle();
        #1;
        chk("br/flush_cnt", hz.flush_cnt, 32'd1);
        chk("br/stall_cnt", hz.stall_cnt, 32'(exp_stall));
        chk("br/flush_off", 32'(hz.flush_d), 32'd0);
        hz.ex_brn_tkn = 1'b1;
        #1;
        $display("branch with empty ID");
        chk("br2/flush_d", 32'(hz.flush_d), 32'd1);
        step();
        hz.ex_brn_tkn = 1'b0;
        chk("br2/flush_cnt", hz.flush_cnt, 32'd2);
        drain();

        // Three ALU ops then ecall
        issue("add_x10", 1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0, 0, 0);
        issue("add_x11", 1, 5'd1, 1, 5'd2, 1, 5'd11, 1, 0, 0, 0);
        issue("add_x12", 1, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 0, 0);
        issue("ecall",   1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
        idle();
        #1;
        chk("drain/halted",  32'(hz.halted),  32'd0);
        chk("drain/stall_f", 32'(hz.stall_f), 32'd1);
        n = 0;
        while (hz.halted !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        $display("ecall drained in %0d cycles", n);
        chk("ecall/latency", 32'(n), 32'd3);
        exp_stall += 3;
        chk("ecall/stall_cnt", hz.stall_cnt, 32'(exp_stall));
        repeat (2) step();
        chk("halt/halted",    32'(hz.halted),   32'd1);
        chk("halt/stall_f",   32'(hz.stall_f),  32'd1);
        chk("halt/bubble_e",  32'(hz.bubble_e), 32'd1);
        chk("halt/stall_cnt", hz.stall_cnt,     32'(exp_stall + 2));

        // Asynchronous reset out of HALT
        #1;
        reset = 1'b0;
        #1;
        $display("async reset from HALT");
        chk("arst/halted",    32'(hz.halted),    32'd0);
        chk("arst/stall_f",   32'(hz.stall_f),   32'd0);
        chk("arst/bubble_e",  32'(hz.bubble_e),  32'd0);
        chk("arst/fwd_a",     32'(hz.fwd_a_sel), 32'd0);
        chk("arst/stall_cnt", hz.stall_cnt,      32'd0);
        chk("arst/flush_cnt", hz.flush_cnt,      32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        exp_stall = 0;

        // Reset during a load-use stall
        issue("lw_x5d", 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);
        drive(1, 5'd5, 1, 5'd2, 1, 5'd6, 1, 0, 0);
        #1;
        chk("mid/stall_f", 32'(hz.stall_f), 32'd1);
        reset = 1'b0;
        #1;
        $display("async reset during stall");
        chk("mid/stall_rst",  32'(hz.stall_f),  32'd0);
        chk("mid/bubble_rst", 32'(hz.bubble_e), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid/post_rst", 32'(hz.stall_f), 32'd0);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
